// File: rtl/ci_cmd_sequencer_if.sv
// Host-side byte handshake and SoC control bundle for ci_cmd_sequencer.
// master: host UART / bench side; slave: the command sequencer.
interface ci_cmd_sequencer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       soc_clk_en;
    logic       soc_reset;
    logic       tx_sel;
    logic       rx_en;

    modport master (
        output rx_valid, rx_data, tx_busy,
        input  tx_en, tx_data,
        input  soc_clk_en, soc_reset, tx_sel, rx_en
    );

    modport slave (
        input  rx_valid, rx_data, tx_busy,
        output tx_en, tx_data,
        output soc_clk_en, soc_reset, tx_sel, rx_en
    );
endinterface

// File: rtl/ci_cmd_sequencer.sv
// Byte-command controller: decodes host bytes, drives SoC clock gate,
// timed reset pulse, N-cycle clock step and tx/rx routing, one reply per command.
// Ports: clk, resetn (async, active low), bus (ci_cmd_sequencer_if.slave):
//   rx_valid/rx_data in, tx_busy in, tx_en/tx_data out,
//   soc_clk_en, soc_reset, tx_sel, rx_en out.
// Optional: define CI_CMD_TIMEOUT_EN to abort argument bytes after TIMEOUT_CYCLES.
module ci_cmd_sequencer #(
    parameter logic [15:0] RESET_CYCLES   = 16'd50,
    parameter int unsigned TIMEOUT_CYCLES = 27000000,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA,
    parameter logic [7:0]  NAK_BYTE       = 8'h55
) (
    input logic              clk,
    input logic              resetn,
    ci_cmd_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARG  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic        r_arg_step;
    logic        r_arg_hi;
    logic [7:0]  r_arg_lo;
    logic [15:0] r_reset_len;
    logic        r_ovf;
    logic        r_clk_en;
    logic        r_tx_sel;
    logic        r_rx_en;
    logic        r_rst_act;
    logic [15:0] r_rst_cnt;
    logic        r_step_act;
    logic [7:0]  r_step_cnt;
    logic [7:0]  r_tx_data;
`ifdef CI_CMD_TIMEOUT_EN
    logic [31:0] r_to_cnt;
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    logic       w_tx_en;
    logic [7:0] w_status;

    // Reply leaves as soon as the transmitter is free; state drops to IDLE
    // on the same edge, so the strobe is one cycle wide.
    assign w_tx_en  = (r_state == S_RESP) && !bus.tx_busy;
    assign w_status = {r_ovf, r_step_act, r_rst_act, r_rx_en,
                       r_tx_sel, r_clk_en, 2'b00};

    assign bus.tx_en      = w_tx_en;
    assign bus.tx_data    = r_tx_data;
    assign bus.soc_clk_en = r_clk_en;
    assign bus.soc_reset  = r_rst_act;
    assign bus.tx_sel     = r_tx_sel;
    assign bus.rx_en      = r_rx_en;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_arg_step  <= 1'b0;
            r_arg_hi    <= 1'b0;
            r_arg_lo    <= 8'h00;
            r_reset_len <= RESET_CYCLES;
            r_ovf       <= 1'b0;
            r_clk_en    <= 1'b1;
            r_tx_sel    <= 1'b0;
            r_rx_en     <= 1'b1;
            r_rst_act   <= 1'b0;
            r_rst_cnt   <= 16'd0;
            r_step_act  <= 1'b0;
            r_step_cnt  <= 8'd0;
            r_tx_data   <= 8'h00;
`ifdef CI_CMD_TIMEOUT_EN
            r_to_cnt    <= 32'd0;
`endif
        end else begin
            // Timers run first; a command on this edge overrides them.
            if (r_rst_act) begin
                if (r_rst_cnt <= 16'd1) r_rst_act <= 1'b0;
                else r_rst_cnt <= r_rst_cnt - 16'd1;
            end
            if (r_step_act) begin
                if (r_step_cnt <= 8'd1) begin
                    r_step_act <= 1'b0;
                    r_clk_en   <= 1'b0;
                end else begin
                    r_step_cnt <= r_step_cnt - 8'd1;
                end
            end

            case (r_state)
                S_IDLE: if (bus.rx_valid) begin
                    r_state   <= S_RESP;
                    r_tx_data <= ACK_BYTE;
                    case (bus.rx_data)
                        8'h00: begin
                            r_clk_en   <= 1'b0;
                            r_step_act <= 1'b0;
                        end
                        8'h01: begin
                            r_clk_en   <= 1'b1;
                            r_step_act <= 1'b0;
                        end
                        8'h02: begin
                            r_rst_act <= 1'b1;
                            r_rst_cnt <= (r_reset_len == 16'd0) ?
                                         16'd1 : r_reset_len;
                        end
                        8'h03: r_rst_act <= 1'b0;
                        8'h04: r_tx_sel  <= 1'b0;
                        8'h05: r_tx_sel  <= 1'b1;
                        8'h06: r_rx_en   <= 1'b1;
                        8'h07: r_rx_en   <= 1'b0;
                        8'h08, 8'h0A: begin
                            r_state    <= S_ARG;
                            r_arg_step <= bus.rx_data[1];
                            r_arg_hi   <= 1'b0;
`ifdef CI_CMD_TIMEOUT_EN
                            r_to_cnt   <= 32'd0;
`endif
                        end
                        8'h09: begin
                            r_tx_data <= w_status;
                            r_ovf     <= 1'b0;
                        end
                        default: r_tx_data <= NAK_BYTE;
                    endcase
                end
                S_ARG: begin
                    if (bus.rx_valid) begin
`ifdef CI_CMD_TIMEOUT_EN
                        r_to_cnt <= 32'd0;
`endif
                        if (r_arg_step) begin
                            r_state    <= S_RESP;
                            r_tx_data  <= ACK_BYTE;
                            r_step_act <= |bus.rx_data;
                            r_step_cnt <= bus.rx_data;
                            r_clk_en   <= |bus.rx_data;
                        end else if (!r_arg_hi) begin
                            r_arg_lo <= bus.rx_data;
                            r_arg_hi <= 1'b1;
                        end else begin
                            r_reset_len <= {bus.rx_data, r_arg_lo};
                            r_state     <= S_RESP;
                            r_tx_data   <= ACK_BYTE;
                        end
                    end
`ifdef CI_CMD_TIMEOUT_EN
                    else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= S_RESP;
                        r_tx_data <= NAK_BYTE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (bus.rx_valid) r_ovf <= 1'b1;
                    if (w_tx_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ci_cmd_sequencer.sv
// Directed bench for ci_cmd_sequencer: cycle-indexed reference model
// checked every cycle, plus literal pulse widths and reply bytes.
module tb_ci_cmd_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    ci_cmd_sequencer_if bus();

    ci_cmd_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int hi_rst = 0;
    int hi_clk = 0;
    logic [7:0] last_tx = 8'h00;
    bit chk_on = 1'b0;

    // Model: outputs expressed as functions of the cycle index.
    int   m_step_until, m_rst_until, m_len, m_resp_from, m_argn;
    bit   m_clk_after, m_tx_sel, m_rx_en, m_ovf, m_pend, m_arg_step;
    logic [7:0] m_resp, m_lo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit e_clk(input int c);
        return (c <= m_step_until) ? 1'b1 : m_clk_after;
    endfunction

    function automatic bit e_rst(input int c);
        return c <= m_rst_until;
    endfunction

    task automatic model_reset();
        m_step_until = -1; m_rst_until = -1; m_len = 50;
        m_clk_after = 1; m_tx_sel = 0; m_rx_en = 1; m_ovf = 0;
        m_pend = 0; m_argn = 0; m_arg_step = 0; m_lo = 0; m_resp = 0;
        m_resp_from = 0;
    endtask

    task automatic respond(input logic [7:0] b, input int k);
        m_pend = 1; m_resp = b; m_resp_from = k + 1;
    endtask

    // Byte b was presented during cycle k; its effects start at k+1.
    task automatic model_rx(input logic [7:0] b, input int k);
        if (m_pend) begin
            m_ovf = 1;
            return;
        end
        if (m_argn > 0) begin
            if (m_arg_step) begin
                m_step_until = (b == 0) ? -1 : k + int'(b);
                m_clk_after = 0;
                m_argn = 0;
                respond(8'hAA, k);
            end else if (m_argn == 2) begin
                m_lo = b; m_argn = 1;
            end else begin
                m_len = int'(b) * 256 + int'(m_lo);
                m_argn = 0;
                respond(8'hAA, k);
            end
            return;
        end
        case (b)
            8'h00: begin m_clk_after = 0; m_step_until = -1; end
            8'h01: begin m_clk_after = 1; m_step_until = -1; end
            8'h02: m_rst_until = k + ((m_len == 0) ? 1 : m_len);
            8'h03: m_rst_until = -1;
            8'h04: m_tx_sel = 0;
            8'h05: m_tx_sel = 1;
            8'h06: m_rx_en = 1;
            8'h07: m_rx_en = 0;
            8'h08: begin m_argn = 2; m_arg_step = 0; end
            8'h0A: begin m_argn = 1; m_arg_step = 1; end
            default: ;
        endcase
        if (m_argn == 0) begin
            if (b == 8'h09) begin
                respond({m_ovf, k <= m_step_until, e_rst(k), m_rx_en,
                         m_tx_sel, e_clk(k), 2'b00}, k);
                m_ovf = 0;
            end else if (b > 8'h0A) begin
                respond(8'h55, k);
            end else begin
                respond(8'hAA, k);
            end
        end
    endtask

    always @(negedge clk) begin : cmp
        bit e_tx;
        if (resetn) begin
            hi_rst += int'(bus.soc_reset);
            hi_clk += int'(bus.soc_clk_en);
            if (bus.tx_en) last_tx = bus.tx_data;
        end
        if (chk_on && resetn) begin
            e_tx = m_pend && (cyc >= m_resp_from) && !bus.tx_busy;
            chk("soc_clk_en", int'(bus.soc_clk_en), int'(e_clk(cyc)));
            chk("soc_reset", int'(bus.soc_reset), int'(e_rst(cyc)));
            chk("tx_sel", int'(bus.tx_sel), int'(m_tx_sel));
            chk("rx_en", int'(bus.rx_en), int'(m_rx_en));
            chk("tx_en", int'(bus.tx_en), int'(e_tx));
            if (e_tx) begin
                chk("tx_data", int'(bus.tx_data), int'(m_resp));
                m_pend = 0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit upd);
        int k;
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        k = cyc;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        if (upd) model_rx(b, k);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_pend && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (m_pend) chk("resp_wait", 1, 0);
        @(negedge clk);
    endtask

    task automatic cmd1(input logic [7:0] a);
        send(a, 1); wait_idle();
    endtask

    task automatic cmd3(input logic [7:0] a, b, c);
        send(a, 1); send(b, 1); send(c, 1); wait_idle();
    endtask

    task automatic cmd2(input logic [7:0] a, b);
        send(a, 1); send(b, 1); wait_idle();
    endtask

    task automatic pulse_width(input string nm, input int exp);
        int h0;
        h0 = hi_rst;
        cmd1(8'h02);
        repeat (exp + 20) @(negedge clk);
        chk(nm, hi_rst - h0, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        model_reset();
        #2 resetn = 1'b0;
        #1;
        chk("rst_clk_en", int'(bus.soc_clk_en), 1);
        chk("rst_soc_reset", int'(bus.soc_reset), 0);
        chk("rst_tx_sel", int'(bus.tx_sel), 0);
        chk("rst_rx_en", int'(bus.rx_en), 1);
        chk("rst_tx_en", int'(bus.tx_en), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk_on = 1'b1;

        pulse_width("pulse_default", 50);
        chk("ack_first", int'(last_tx), 8'hAA);
        cmd3(8'h08, 8'h0A, 8'h00);
        pulse_width("pulse_len10", 10);
        cmd3(8'h08, 8'h00, 8'h00);
        pulse_width("pulse_len0", 1);

        cmd1(8'h00);
        h0 = hi_clk;
        cmd2(8'h0A, 8'h05);
        repeat (20) @(negedge clk);
        chk("step5", hi_clk - h0, 5);
        h0 = hi_clk;
        cmd2(8'h0A, 8'h00);
        repeat (20) @(negedge clk);
        chk("step0", hi_clk - h0, 0);
        cmd1(8'h01);

        // Reply held off by a busy transmitter; a byte during it is dropped.
        @(posedge clk); #1 bus.tx_busy = 1'b1;
        send(8'h05, 1);
        send(8'h07, 1);
        repeat (200) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
        wait_idle();
        chk("busy_ack", int'(last_tx), 8'hAA);
        cmd1(8'h09);
        chk("status_ovf", int'(last_tx), 8'h9C);
        cmd1(8'h09);
        chk("status_clr", int'(last_tx), 8'h1C);
        cmd1(8'h3F);
        chk("nak", int'(last_tx), 8'h55);
        cmd1(8'h04);
        cmd1(8'h04);
        cmd1(8'h06);

        // Pulse in flight keeps its length after reset_len changes.
        cmd3(8'h08, 8'h14, 8'h00);
        h0 = hi_rst;
        cmd1(8'h02);
        cmd3(8'h08, 8'h03, 8'h00);
        repeat (40) @(negedge clk);
        chk("pulse_kept", hi_rst - h0, 20);
        pulse_width("pulse_new", 3);
        cmd1(8'h02);
        cmd1(8'h03);
        cmd1(8'h02);
        repeat (10) @(negedge clk);

`ifdef CI_CMD_TIMEOUT_EN
        chk_on = 1'b0;
        send(8'h08, 0);
        send(8'h12, 0);
        begin : to_wait
            int n;
            n = 0;
            while (!bus.tx_en && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_nak", int'(bus.tx_data), 8'h55);
            chk("timeout_seen", int'(bus.tx_en), 1);
        end
        @(negedge clk);
        chk_on = 1'b1;
        pulse_width("pulse_after_to", 3);
`endif

        cmd1(8'h05);
        cmd1(8'h07);
        cmd3(8'h08, 8'h28, 8'h00);
        cmd1(8'h02);
        cmd2(8'h0A, 8'h1E);
        repeat (5) @(negedge clk);
        chk("pre_rst_pulse", int'(bus.soc_reset), 1);
        #2 chk_on = 1'b0;
        resetn = 1'b0;
        #1;
        chk("amid_clk_en", int'(bus.soc_clk_en), 1);
        chk("amid_soc_reset", int'(bus.soc_reset), 0);
        chk("amid_tx_sel", int'(bus.tx_sel), 0);
        chk("amid_rx_en", int'(bus.rx_en), 1);
        chk("amid_tx_en", int'(bus.tx_en), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk_on = 1'b1;
        cmd1(8'h09);
        chk("status_post_rst", int'(last_tx), 8'h14);
        pulse_width("pulse_post_rst", 50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
